// File: rtl/divider_32bit.sv
// Sequential 32-bit radix-2 restoring divider with a start/done level handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module divider_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic        div_by_zero
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] FINISH  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] a_orig_q, a_orig_d;
  logic [31:0] quot_out_q, quot_out_d;
  logic [31:0] rem_out_q, rem_out_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] quot_final, rem_final;

`ifdef DIVIDER_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  assign a_mag      = a[31] ? 32'd0 - a : a;
  assign b_mag      = b[31] ? 32'd0 - b : b;
  assign quot_final = neg_quot_q ? 32'd0 - dvd_q : dvd_q;
  assign rem_final  = neg_rem_q ? 32'd0 - rem_q : rem_q;
`else
  assign a_mag      = a;
  assign b_mag      = b;
  assign quot_final = dvd_q;
  assign rem_final  = rem_q;
`endif

  // With trial[32] set the trial exceeds any 32-bit divisor and the difference fits 32 bits.
  assign trial = {rem_q, dvd_q[31]};
  assign qbit  = trial[32] | (trial[31:0] >= dsr_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    a_orig_d   = a_orig_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    done_d     = done_q;
    dbz_d      = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d  = COMPUTE;
          cnt_d    = 5'd0;
          dvd_d    = a_mag;
          dsr_d    = b_mag;
          rem_d    = 32'd0;
          a_orig_d = a;
          dbz_d    = 1'b0;
`ifdef DIVIDER_SIGNED_EN
          neg_quot_d = a[31] ^ b[31];
          neg_rem_d  = a[31];
`endif
        end
      end
      COMPUTE: begin
        rem_d = qbit ? trial[31:0] - dsr_q : trial[31:0];
        dvd_d = {dvd_q[30:0], qbit};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (dsr_q == 32'd0) begin
          quot_out_d = 32'hFFFF_FFFF;
          rem_out_d  = a_orig_q;
          dbz_d      = 1'b1;
        end else begin
          quot_out_d = quot_final;
          rem_out_d  = rem_final;
          dbz_d      = 1'b0;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      dvd_q      <= 32'd0;
      dsr_q      <= 32'd0;
      rem_q      <= 32'd0;
      a_orig_q   <= 32'd0;
      quot_out_q <= 32'd0;
      rem_out_q  <= 32'd0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      a_orig_q   <= a_orig_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit: directed cases plus random operands against
// a plain-arithmetic reference model; follows DIVIDER_SIGNED_EN like the RTL.
module tb_divider_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider_32bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .quotient    (quotient),
    .remainder   (remainder),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ta, input logic [31:0] tb_v,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    int sa;
    int sb;
    sa = ta;
    sb = tb_v;
    dz = 1'b0;
    if (tb_v == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = ta;
      dz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      if (ta == 32'h8000_0000 && tb_v == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = ta / tb_v;
      r = ta % tb_v;
`endif
    end
  endfunction

  // One full operation: accept, wait for done, check results and handshake release.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit hold,
                       input bit scramble, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          lat;
    model(ta, tb_v, eq, er, edz);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    if (scramble) begin
      a = $urandom;
      b = $urandom;
    end
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (done === 1'b1) break;
    end
    check({tag, " latency"}, lat, 33);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      check({tag, " done held"}, {31'd0, done}, 32'd1);
      check({tag, " quotient held"}, quotient, eq);
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    check({tag, " done released"}, {31'd0, done}, 32'd0);
    check({tag, " quotient after release"}, quotient, eq);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    #23;
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'd100, 32'd7, 1'b0, 1'b0, "basic");
    do_op(32'd5, 32'd0, 1'b0, 1'b0, "div0");
    do_op(32'd100, 32'd7, 1'b0, 1'b0, "after div0");
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "neg7 by 2");
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "min by -1");
    do_op(32'd1000, 32'd33, 1'b1, 1'b0, "hold start");
    do_op(32'd77777, 32'd123, 1'b0, 1'b1, "scramble");
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "max by 1");
    do_op(32'd3, 32'd10, 1'b0, 1'b0, "small by big");

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      do_op(ra, rb, i % 5 == 0, i % 3 == 0, "random");
    end

    do_op(32'd12345, 32'd100, 1'b0, 1'b0, "pre reset");
    @(negedge clk);
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset quotient", quotient, 32'd0);
    check("midreset remainder", remainder, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("no stale done", {31'd0, done}, 32'd0);
    do_op(32'd9, 32'd3, 1'b0, 1'b0, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
